// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin write-side arbiter that shares a single sync_fifo write port
// between NUM_REQ valid/ready requesters. One requester at a time holds a
// grant for a burst of up to MAX_BURST beats. Priority then rotates to the
// requester after the last grant holder. Grant decisions are registered.
// The path from the current grant to the FIFO write strobe is combinational.
//
// Optional build macro: FIFO_WR_ARBITER_STATS_EN
//   Adds beat_count, which holds one saturating 16-bit beat counter per
//   requester.
//
// Ports:
//   clk           : clock
//   rst_n         : asynchronous active-low reset
//   req_valid     : per-requester beat valid                 [NUM_REQ]
//   req_data      : requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     : per-requester accept, one-hot or zero    [NUM_REQ]
//   fifo_write    : write strobe to the FIFO
//   fifo_wr_data  : write data to the FIFO                   [DATA_WIDTH]
//   fifo_wr_full  : FIFO full flag
//   grant_valid   : a grant is currently held
//   grant_id      : index of the current grant holder        [IW]
//   beat_count    : (stats build only) per-requester counters [NUM_REQ*16]
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int IW         = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_write,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_wr_full,
    output logic                          grant_valid,
    output logic [IW-1:0]                 grant_id
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         beat_count
`endif
);

    // The burst counter only has to reach MAX_BURST-1.
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_grant_valid;
    logic [IW-1:0]   r_grant_id;
    logic [IW-1:0]   r_last_grant;
    logic [CW-1:0]   r_burst_cnt;

    logic            w_xfer;
    logic            w_any_req;
    logic [IW-1:0]   w_winner;
    logic [NUM_REQ-1:0] w_ready;
    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

    // Index that is k positions after base, wrapping modulo NUM_REQ.
    // This also works when NUM_REQ is not a power of two.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_REQ;
        return IW'(s);
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign w_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search that starts one position after the last holder.
    // The loop walks from the farthest candidate to the nearest one, so the
    // last match written is the nearest requesting index.
    always_comb begin
        w_winner = r_last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[rr_idx(r_last_grant, k)]) begin
                w_winner = rr_idx(r_last_grant, k);
            end
        end
    end

    assign w_any_req = |req_valid;

    always_comb begin
        w_ready = '0;
        if (r_grant_valid && !fifo_wr_full) begin
            w_ready[r_grant_id] = 1'b1;
        end
    end

    assign w_xfer       = r_grant_valid & req_valid[r_grant_id] & ~fifo_wr_full;
    assign req_ready    = w_ready;
    assign fifo_write   = w_xfer;
    assign fifo_wr_data = w_slice[r_grant_id];
    assign grant_valid  = r_grant_valid;
    assign grant_id     = r_grant_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_burst_cnt   <= '0;
            r_last_grant  <= IW'(NUM_REQ - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_id    <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_burst_cnt   <= '0;
                        r_state       <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_xfer) begin
                        if (r_burst_cnt == LAST_BEAT) begin
                            r_last_grant  <= r_grant_id;
                            r_grant_valid <= 1'b0;
                            r_burst_cnt   <= '0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_burst_cnt <= r_burst_cnt + CW'(1);
                        end
                    end else if (!req_valid[r_grant_id]) begin
                        // The holder went idle. A full-FIFO stall with the
                        // holder still valid keeps the grant indefinitely.
                        r_last_grant  <= r_grant_id;
                        r_grant_valid <= 1'b0;
                        r_burst_cnt   <= '0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_grant_valid <= 1'b0;
                    r_burst_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [15:0] r_beat_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_beat_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_xfer && (r_grant_id == IW'(i)) && (r_beat_cnt[i] != 16'hFFFF)) begin
                    r_beat_cnt[i] <= r_beat_cnt[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        assign beat_count[g*16 +: 16] = r_beat_cnt[g];
    end
`endif

endmodule
